uart_out_packer: RTL and testbench

//  CPU-side output adapter feeding the UART transmit buffer (uart_back). Accepts byte/word
//  "out" writes from the core and queues them in a small FIFO. Serialises each entry into

---
 rtl/uart_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_out_packer.sv | 160 ++++++++++++++++
 tb/tb_uart_out_packer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART output packer.
//   out_size_t     : width of a core "out" write (single byte or 32-bit word)
//   packer_state_t : serialiser FSM states
//   out_entry_t    : one queued request, {size, data}
//   UART_CNT_W     : width of the emitted-byte counter
package uart_pkg;

    localparam int unsigned UART_CNT_W = 18;

    typedef enum logic {
        OUT_BYTE = 1'b0,
        OUT_WORD = 1'b1
    } out_size_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2
    } packer_state_t;

    typedef struct packed {
        out_size_t   size;
        logic [31:0] data;
    } out_entry_t;

    // Index of the final byte of an entry: 3 for words, 0 for bytes.
    function automatic logic [1:0] last_index(input out_size_t s);
        return (s == OUT_WORD) ? 2'd3 : 2'd0;
    endfunction

    // Byte lane i of a word, LSB lane first.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        logic [31:0] sh;
        sh = w >> {i, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rstn : clock, asynchronous active-low reset (pointers only)
//   push/wdata: write request; ignored while full
//   pop       : consume head entry; ignored while empty
//   rdata     : head entry, valid whenever !empty
//   full/empty: occupancy flags
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_out_packer.sv
// CPU-side output adapter in front of the UART transmit buffer.
// Queues byte/word writes, serialises them LSB first as one-cycle byte
// strobes separated by idle gaps, and raises a sticky send-enable.
//   clk, rstn     : clock, asynchronous active-low reset
//   out_valid     : core write request
//   out_data      : payload; byte mode uses [7:0]
//   out_size      : 0 = byte, 1 = word (4 bytes, LSB first)
//   out_ready     : request queue can accept
//   done          : end-of-program pulse
//   byte_data     : byte to the transmit buffer
//   byte_valid    : one-cycle strobe per byte
//   send_en       : sticky send-enable to the transmit buffer
//   bytes_emitted : bytes strobed since reset, saturating at BUF_BYTES
//   overflow      : sticky, a byte was dropped at capacity
module uart_out_packer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned GAP_CYCLES      = 1,
    parameter int unsigned FLUSH_THRESHOLD = 0,
    parameter int unsigned BUF_BYTES       = 50000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  out_valid,
    input  logic [31:0]           out_data,
    input  logic                  out_size,
    output logic                  out_ready,
    input  logic                  done,
    output logic [7:0]            byte_data,
    output logic                  byte_valid,
    output logic                  send_en,
    output logic [UART_CNT_W-1:0] bytes_emitted,
    output logic                  overflow
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [UART_CNT_W-1:0] CAP      = UART_CNT_W'(BUF_BYTES);
    localparam logic [UART_CNT_W-1:0] THR      = UART_CNT_W'(FLUSH_THRESHOLD);

    packer_state_t    state;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       byte_idx;
    logic [1:0]       last_idx;
    logic [31:0]      word_q;
    logic             done_q;
    logic             ready_en;

    out_entry_t       fifo_wr;
    out_entry_t       fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;

    logic             gap_done;
    logic             more_bytes;
    logic             load;
    logic             emit_now;
    logic [7:0]       emit_byte;
    logic             at_cap;

    // ready_en keeps out_ready low throughout reset despite the FIFO being empty.
    assign out_ready = ready_en && !fifo_full;
    assign push      = out_valid && out_ready;
    assign fifo_wr   = '{size: out_size_t'(out_size), data: out_data};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(out_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (fifo_wr),
        .pop   (load),
        .rdata (fifo_rd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign gap_done   = (state == S_GAP) && (gap_cnt == GAP_W'(1));
    assign more_bytes = (byte_idx != last_idx);
    // A new entry is taken from idle, or straight after the last byte's gap.
    assign load       = !fifo_empty && ((state == S_IDLE) || (gap_done && !more_bytes));
    assign emit_now   = load || (gap_done && more_bytes);
    assign emit_byte  = load ? byte_of(fifo_rd.data, 2'd0)
                             : byte_of(word_q, byte_idx + 2'd1);
    assign at_cap     = (bytes_emitted == CAP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            gap_cnt       <= '0;
            byte_idx      <= '0;
            last_idx      <= '0;
            word_q        <= '0;
            done_q        <= 1'b0;
            ready_en      <= 1'b0;
            byte_data     <= '0;
            byte_valid    <= 1'b0;
            send_en       <= 1'b0;
            bytes_emitted <= '0;
            overflow      <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            byte_valid <= 1'b0;
            if (done) done_q <= 1'b1;

            // The strobe is registered on entry to S_EMIT so it is high for
            // exactly the S_EMIT cycle. At capacity the slot is kept but silent.
            if (emit_now) begin
                if (at_cap) begin
                    overflow <= 1'b1;
                end else begin
                    byte_valid    <= 1'b1;
                    byte_data     <= emit_byte;
                    bytes_emitted <= bytes_emitted + UART_CNT_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (load) begin
                        word_q   <= fifo_rd.data;
                        last_idx <= last_index(fifo_rd.size);
                        byte_idx <= 2'd0;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    gap_cnt <= GAP_LOAD;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_done) begin
                        if (more_bytes) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_EMIT;
                        end else if (load) begin
                            word_q   <= fifo_rd.data;
                            last_idx <= last_index(fifo_rd.size);
                            byte_idx <= 2'd0;
                            state    <= S_EMIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            if ((bytes_emitted >= THR) || (done_q && fifo_empty && (state == S_IDLE)))
                send_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_out_packer.sv
// Self-checking bench for uart_out_packer: two instances with different
// parameter sets, a byte-stream reference model built from accepted writes,
// and a monitor checking strobe spacing.
module tb_uart_out_packer;

    localparam int unsigned A_DEPTH = 4;
    localparam int unsigned A_GAP   = 1;
    localparam int unsigned A_THR   = 4;
    localparam int unsigned A_BUF   = 50000;
    localparam int unsigned B_DEPTH = 2;
    localparam int unsigned B_GAP   = 3;
    localparam int unsigned B_THR   = 0;
    localparam int unsigned B_BUF   = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0, a_size = 1'b0, a_done = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_ready, a_bvalid, a_send, a_ovf;
    logic [7:0]  a_bdata;
    logic [17:0] a_cnt;

    logic        b_valid = 1'b0, b_size = 1'b0, b_done = 1'b0;
    logic [31:0] b_data = '0;
    logic        b_ready, b_bvalid, b_send, b_ovf;
    logic [7:0]  b_bdata;
    logic [17:0] b_cnt;

    uart_out_packer #(
        .DEPTH(A_DEPTH), .GAP_CYCLES(A_GAP), .FLUSH_THRESHOLD(A_THR), .BUF_BYTES(A_BUF)
    ) dut_a (
        .clk(clk), .rstn(rstn), .out_valid(a_valid), .out_data(a_data), .out_size(a_size),
        .out_ready(a_ready), .done(a_done), .byte_data(a_bdata), .byte_valid(a_bvalid),
        .send_en(a_send), .bytes_emitted(a_cnt), .overflow(a_ovf)
    );

    uart_out_packer #(
        .DEPTH(B_DEPTH), .GAP_CYCLES(B_GAP), .FLUSH_THRESHOLD(B_THR), .BUF_BYTES(B_BUF)
    ) dut_b (
        .clk(clk), .rstn(rstn), .out_valid(b_valid), .out_data(b_data), .out_size(b_size),
        .out_ready(b_ready), .done(b_done), .byte_data(b_bdata), .byte_valid(b_bvalid),
        .send_en(b_send), .bytes_emitted(b_cnt), .overflow(b_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] a_got[$], a_exp[$], b_got[$], b_exp[$];
    int         a_last = -1, b_last = -1;
    bit         a_saw_full = 0, b_drop = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Collect strobes and check the minimum spacing of GAP+1 cycles.
    always @(negedge clk) begin
        if (a_bvalid === 1'b1) begin
            if (a_last >= 0) check("a_spacing", 32'((cyc - a_last) >= int'(A_GAP + 1)), 32'd1);
            a_got.push_back(a_bdata);
            a_last = cyc;
        end
        if (b_bvalid === 1'b1) begin
            if (b_last >= 0) check("b_spacing", 32'((cyc - b_last) >= int'(B_GAP + 1)), 32'd1);
            b_got.push_back(b_bdata);
            b_last = cyc;
        end
        if (rstn && a_valid && !a_ready) a_saw_full = 1;
    end

    // Expected stream: bytes of every accepted write, LSB first, up to capacity.
    task automatic model_push(input bit which, input logic sz, input logic [31:0] d);
        int n;
        n = sz ? 4 : 1;
        for (int i = 0; i < n; i++) begin
            if (!which) begin
                if (a_exp.size() < int'(A_BUF)) a_exp.push_back(d[8*i +: 8]);
            end else begin
                if (b_exp.size() < int'(B_BUF)) b_exp.push_back(d[8*i +: 8]);
                else b_drop = 1;
            end
        end
    endtask

    task automatic do_write(input bit which, input logic sz, input logic [31:0] d);
        int unsigned w;
        w = 0;
        @(negedge clk);
        if (!which) begin a_valid = 1; a_size = sz; a_data = d; end
        else        begin b_valid = 1; b_size = sz; b_data = d; end
        while (((!which && !a_ready) || (which && !b_ready)) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            check(which ? "b_accept_timeout" : "a_accept_timeout", 32'(w), 32'd0);
        end else begin
            @(posedge clk);
            model_push(which, sz, d);
        end
        #1;
        a_valid = 0;
        b_valid = 0;
    endtask

    task automatic wait_drain(input bit which);
        int unsigned w;
        w = 0;
        while (w < 3000 && (which ? (b_got.size() < b_exp.size())
                                  : (a_got.size() < a_exp.size()))) begin
            @(negedge clk);
            w++;
        end
        repeat (24) @(negedge clk);
    endtask

    task automatic cmp_stream(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0;
        a_valid = 0; b_valid = 0; a_done = 0; b_done = 0;
        #1;
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_a_bvalid", 32'(a_bvalid), 32'd0);
        check("rst_a_bdata", 32'(a_bdata), 32'd0);
        check("rst_a_cnt", 32'(a_cnt), 32'd0);
        check("rst_a_send", 32'(a_send), 32'd0);
        check("rst_a_ovf", 32'(a_ovf), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_b_send", 32'(b_send), 32'd0);
        check("rst_b_ovf", 32'(b_ovf), 32'd0);
        a_got.delete(); a_exp.delete(); b_got.delete(); b_exp.delete();
        a_last = -1; b_last = -1; a_saw_full = 0; b_drop = 0;
        repeat (2) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        check("post_rst_a_ready", 32'(a_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_ready), 32'd1);
        check("post_rst_a_send", 32'(a_send), 32'd0);
        check("post_rst_b_send", 32'(b_send), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned w;
        logic [31:0] d;
        logic        sz;

        // Single byte, then a word: order, count, threshold-driven send_en.
        do_reset();
        do_write(0, 1'b0, 32'h0000_0041);
        wait_drain(0);
        cmp_stream("a_byte", a_got, a_exp);
        check("a_byte_cnt", 32'(a_cnt), 32'd1);
        check("a_byte_send", 32'(a_send), 32'd0);
        do_write(0, 1'b1, 32'h4433_2211);
        wait_drain(0);
        cmp_stream("a_word", a_got, a_exp);
        check("a_word_last", 32'(a_bdata), 32'h44);
        check("a_word_cnt", 32'(a_cnt), 32'd5);
        check("a_word_send", 32'(a_send), 32'd1);

        // DEPTH+2 back-to-back random words: backpressure, no loss.
        do_reset();
        for (int i = 0; i < int'(A_DEPTH) + 2; i++) do_write(0, 1'b1, $urandom);
        wait_drain(0);
        check("a_full_seen", 32'(a_saw_full), 32'd1);
        cmp_stream("a_burst", a_got, a_exp);
        check("a_burst_cnt", 32'(a_cnt), 32'(4 * (A_DEPTH + 2)));
        check("a_burst_ovf", 32'(a_ovf), 32'd0);

        // Random mix of sizes and idle gaps.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sz = 1'($urandom_range(0, 1));
            d  = $urandom;
            do_write(0, sz, d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain(0);
        cmp_stream("a_mix", a_got, a_exp);
        check("a_mix_cnt", 32'(a_cnt), 32'(a_exp.size()));

        // Three bytes below the threshold, then done: send_en waits for the drain.
        do_reset();
        for (int i = 0; i < 3; i++) do_write(0, 1'b0, 32'($urandom_range(0, 255)));
        @(negedge clk); a_done = 1;
        @(negedge clk); a_done = 0;
        check("a_done_early_send", 32'(a_send), 32'd0);
        wait_drain(0);
        check("a_done_send", 32'(a_send), 32'd1);
        check("a_done_cnt", 32'(a_cnt), 32'd3);
        cmp_stream("a_done", a_got, a_exp);
        repeat (20) @(negedge clk);
        check("a_done_sticky", 32'(a_send), 32'd1);
        do_write(0, 1'b0, 32'h0000_005A);
        wait_drain(0);
        cmp_stream("a_after_done", a_got, a_exp);
        check("a_after_done_send", 32'(a_send), 32'd1);

        // Capacity 6, two words: 6 strobes, overflow, count holds.
        do_reset();
        do_write(1, 1'b1, $urandom);
        do_write(1, 1'b1, $urandom);
        wait_drain(1);
        repeat (20) @(negedge clk);
        cmp_stream("b_cap", b_got, b_exp);
        check("b_cap_cnt", 32'(b_cnt), 32'(B_BUF));
        check("b_cap_ovf", 32'(b_ovf), 32'(b_drop));
        check("b_cap_send", 32'(b_send), 32'd1);

        // Reset asserted while the second byte of a word is on the strobe.
        do_reset();
        do_write(0, 1'b1, 32'h4433_2211);
        w = 0;
        while (!(a_bvalid === 1'b1 && a_bdata === 8'h22) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("a_mid_found", 32'(w < 100), 32'd1);
        rstn = 0;
        #1;
        check("a_mid_bvalid", 32'(a_bvalid), 32'd0);
        check("a_mid_cnt", 32'(a_cnt), 32'd0);
        check("a_mid_ready", 32'(a_ready), 32'd0);
        check("a_mid_bdata", 32'(a_bdata), 32'd0);
        a_got.delete(); a_exp.delete(); a_last = -1;
        repeat (2) @(negedge clk);
        rstn = 1;
        repeat (30) @(negedge clk);
        check("a_mid_no_residual", 32'(a_got.size()), 32'd0);
        check("a_mid_cnt_after", 32'(a_cnt), 32'd0);
        check("a_mid_ovf_after", 32'(a_ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
